// File: rtl/dadda_arb_pkg.sv
// Shared types and constants for the dadda_mul_arbiter slice.
package dadda_arb_pkg;

  localparam int unsigned MUL_WIDTH = 24;

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    DONE,
    HOLD
  } arb_state_t;

endpackage

// File: rtl/dadda_24bit.sv
// Combinational 24x24 multiplier; returns the low 24 bits of a*b.
module dadda_24bit
  import dadda_arb_pkg::*;
(
  input  logic [MUL_WIDTH-1:0] a,
  input  logic [MUL_WIDTH-1:0] b,
  output logic [MUL_WIDTH-1:0] p
);

  // Partial products truncated to the kept width; upper bits never affect the low half.
  always_comb begin
    p = '0;
    for (int unsigned i = 0; i < MUL_WIDTH; i++) begin
      if (b[i]) p = p + (a << i);
    end
  end

endmodule

// File: rtl/dadda_mul_arbiter_rr.sv
// Combinational round-robin arbiter: first valid request at or after rr_ptr, with wrap.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               grant_any
);

  always_comb begin
    int unsigned   idx;
    logic [IDX_W-1:0] cand;
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    idx       = 0;
    cand      = '0;
    for (int unsigned off = 0; off < NUM_REQ; off++) begin
      idx  = (32'(rr_ptr) + off) % NUM_REQ;
      cand = IDX_W'(idx);
      if (!grant_any && req_valid[cand]) begin
        grant_any   = 1'b1;
        grant_idx   = cand;
        grant[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dadda_mul_arbiter.sv
// Round-robin sharing of one dadda_24bit among NUM_REQ requesters, one op in flight.
// Optional DADDA_ARB_ZERO_BYPASS_EN: zero operand skips MUL and answers one cycle early.
module dadda_mul_arbiter
  import dadda_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned WIDTH   = MUL_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic [NUM_REQ-1:0]       rsp_valid,
  input  logic [NUM_REQ-1:0]       rsp_ready,
  output logic [WIDTH-1:0]         rsp_out,
  output logic                     busy
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  arb_state_t       state, state_nxt;
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] owner;
  logic [WIDTH-1:0] op_a, op_b;
  logic [WIDTH-1:0] a_sel, b_sel;
  logic [WIDTH-1:0] product;
  logic [NUM_REQ-1:0] grant;
  logic [IDX_W-1:0] grant_idx;
  logic             grant_any;
  logic             accept;
  logic             zero_hit;
  logic             mul_load;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr (
    .req_valid (req_valid),
    .rr_ptr    (rr_ptr),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_any (grant_any)
  );

  dadda_24bit u_mul (
    .a (op_a),
    .b (op_b),
    .p (product)
  );

  always_comb begin
    a_sel = req_a[grant_idx*WIDTH +: WIDTH];
    b_sel = req_b[grant_idx*WIDTH +: WIDTH];
  end

  always_comb begin
    state_nxt = state;
    req_ready = '0;
    rsp_valid = '0;
    accept    = 1'b0;
    zero_hit  = 1'b0;
    mul_load  = 1'b0;
    busy      = (state != IDLE);
    case (state)
      IDLE: begin
        // Gated by rst so req_ready stays low while reset is held.
        if (grant_any && rst) begin
          accept    = 1'b1;
          req_ready = grant;
`ifdef DADDA_ARB_ZERO_BYPASS_EN
          zero_hit  = (a_sel == '0) || (b_sel == '0);
`endif
          state_nxt = zero_hit ? DONE : MUL;
        end
      end
      MUL: begin
        mul_load  = 1'b1;
        state_nxt = DONE;
      end
      DONE, HOLD: begin
        rsp_valid[owner] = 1'b1;
        state_nxt = rsp_ready[owner] ? IDLE : HOLD;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      rr_ptr  <= '0;
      owner   <= '0;
      op_a    <= '0;
      op_b    <= '0;
      rsp_out <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        op_a   <= a_sel;
        op_b   <= b_sel;
        owner  <= grant_idx;
        rr_ptr <= (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + IDX_W'(1);
        if (zero_hit) rsp_out <= '0;
      end
      if (mul_load) rsp_out <= product;
    end
  end

endmodule

// File: tb/tb_dadda_mul_arbiter.sv
// Directed self-checking bench for dadda_mul_arbiter (NUM_REQ=4, WIDTH=24).
module tb_dadda_mul_arbiter;

  localparam int unsigned N = 4;
  localparam int unsigned W = 24;

  logic           clk;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_a;
  logic [N*W-1:0] req_b;
  logic [N-1:0]   req_ready;
  logic [N-1:0]   rsp_valid;
  logic [N-1:0]   rsp_ready;
  logic [W-1:0]   rsp_out;
  logic           busy;

  int checks = 0;
  int errors = 0;

  dadda_mul_arbiter #(
    .NUM_REQ (N),
    .WIDTH   (W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_out   (rsp_out),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic set_op(input int unsigned i, input logic [W-1:0] a, input logic [W-1:0] b);
    req_a[i*W +: W] = a;
    req_b[i*W +: W] = b;
  endtask

  task automatic cyc;
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst       = 1'b0;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = '0;
    #1;
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_out",   32'(rsp_out),   32'd0);
    check("rst_busy",      32'(busy),      32'd0);
    cyc(); cyc();
    rst = 1'b1;

    // Round robin: all four pending, a=i+1, b=10; grants 0,1,2,3,0
    for (int unsigned i = 0; i < N; i++) set_op(i, W'(i + 1), 24'd10);
    rsp_ready = 4'hF;
    for (int unsigned k = 0; k < 5; k++) begin
      logic [N-1:0] g1h;
      g1h = N'(1) << (k % N);
      cyc(); req_valid = 4'hF; #1;
      check("rr_grant", 32'(req_ready), 32'(g1h));
      cyc(); #1;
      check("rr_mul_noready", 32'(req_ready), 32'd0);
      check("rr_mul_busy", 32'(busy), 32'd1);
      cyc(); #1;
      check("rr_rsp_valid", 32'(rsp_valid), 32'(g1h));
      check("rr_onehot", 32'($onehot(rsp_valid)), 32'd1);
      check("rr_product", 32'(rsp_out), 32'(((k % N) + 1) * 10));
    end
    req_valid = '0;

    // Single multiply from requester 0 (pointer is 1, search wraps to 0)
    cyc(); set_op(0, 24'd3, 24'd5); req_valid = 4'b0001; #1;
    check("single_ready_T", 32'(req_ready), 32'b0001);
    cyc(); req_valid = '0; #1;
    check("single_T1_valid", 32'(rsp_valid), 32'd0);
    cyc(); #1;
    check("single_T2_valid", 32'(rsp_valid), 32'b0001);
    check("single_T2_out", 32'(rsp_out), 32'd15);
    cyc(); #1;
    check("single_T3_busy", 32'(busy), 32'd0);

    // Backpressure on requester 2; other rsp_ready bits high must be ignored
    set_op(2, 24'd95562, 24'd124);
    set_op(0, 24'd4096, 24'd4096);
    set_op(1, 24'd9556, 24'd124);
    rsp_ready = 4'b1011;
    req_valid = 4'b0100; #1;
    check("bp_grant", 32'(req_ready), 32'b0100);
    cyc(); req_valid = 4'b0011; #1;
    check("bp_mul_noready", 32'(req_ready), 32'd0);
    for (int unsigned c = 0; c < 5; c++) begin
      cyc(); #1;
      check("bp_hold_valid", 32'(rsp_valid), 32'b0100);
      check("bp_hold_out", 32'(rsp_out), 32'd11849688);
      check("bp_hold_noready", 32'(req_ready), 32'd0);
      check("bp_hold_busy", 32'(busy), 32'd1);
    end
    cyc(); rsp_ready = 4'hF; #1;
    check("bp_release_valid", 32'(rsp_valid), 32'b0100);
    cyc(); #1;
    check("bp_after_valid", 32'(rsp_valid), 32'd0);
    check("ovf_grant0", 32'(req_ready), 32'b0001);
    cyc(); req_valid = 4'b0010; #1;
    cyc(); #1;
    check("ovf_valid", 32'(rsp_valid), 32'b0001);
    check("ovf_out", 32'(rsp_out), 32'd0);
    cyc(); #1;
    check("wide_grant1", 32'(req_ready), 32'b0010);
    cyc(); req_valid = '0; #1;
    cyc(); #1;
    check("wide_valid", 32'(rsp_valid), 32'b0010);
    check("wide_out", 32'(rsp_out), 32'd1184944);

    // Zero operand from requester 3 (pointer is 2)
    cyc(); set_op(3, 24'd15, 24'd0); req_valid = 4'b1000; #1;
    check("zero_grant", 32'(req_ready), 32'b1000);
    cyc(); req_valid = '0; #1;
`ifdef DADDA_ARB_ZERO_BYPASS_EN
    check("zero_T1_valid", 32'(rsp_valid), 32'b1000);
    check("zero_T1_out", 32'(rsp_out), 32'd0);
    cyc(); #1;
    check("zero_T2_idle", 32'(busy), 32'd0);
`else
    check("zero_T1_valid", 32'(rsp_valid), 32'd0);
    cyc(); #1;
    check("zero_T2_valid", 32'(rsp_valid), 32'b1000);
    check("zero_T2_out", 32'(rsp_out), 32'd0);
    cyc(); #1;
    check("zero_T3_idle", 32'(busy), 32'd0);
`endif

    // Reset during MUL; requester 1 pending, pointer must return to 0
    cyc(); set_op(0, 24'd7, 24'd7); req_valid = 4'b0001; #1;
    check("rstmid_grant0", 32'(req_ready), 32'b0001);
    cyc(); req_valid = 4'b0011; #1;
    check("rstmid_in_mul", 32'(busy), 32'd1);
    rst = 1'b0; #1;
    check("rstmid_busy", 32'(busy), 32'd0);
    check("rstmid_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rstmid_rsp_out", 32'(rsp_out), 32'd0);
    check("rstmid_req_ready", 32'(req_ready), 32'd0);
    cyc(); rst = 1'b1; #1;
    check("rstmid_regrant0", 32'(req_ready), 32'b0001);
    cyc(); req_valid = '0; #1;
    cyc(); #1;
    check("rstmid_valid", 32'(rsp_valid), 32'b0001);
    check("rstmid_out", 32'(rsp_out), 32'd49);
    cyc(); #1;
    check("final_idle", 32'(busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
